// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART state encoding, default bit timing and register map.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP,
    BREAK = ST_BREAK
  } rx_state_e;

  // Peripheral hub addresses shared by the RX, TX and hub blocks
  localparam logic [31:0] UART_TX_ADDR    = 32'h1001_002C;
  localparam logic [31:0] UART_RX_ADDR    = 32'h1001_0030;
  localparam logic [31:0] UART_BUSY_ADDR  = 32'h1001_0034;
  localparam logic [31:0] UART_READY_ADDR = 32'h1001_0038;

endpackage

`default_nettype wire

// File: rtl/uart_rx_if.sv
// ============================================================================
// Module   : uart_rx_if
// Purpose  : Serial line, acknowledge and status bundle between hub and RX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_if;
  logic       rx;
  logic       clear_ready;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_error;
  logic       overrun;

  modport master (
    output rx,
    output clear_ready,
    input  rx_data,
    input  rx_ready,
    input  frame_error,
    input  overrun
  );

  modport slave (
    input  rx,
    input  clear_ready,
    output rx_data,
    output rx_ready,
    output frame_error,
    output overrun
  );
endinterface

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Purpose  : 1-bit two-flop synchroniser for asynchronous inputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic d,
  output logic      q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 serial receiver with sticky ready, framing and overrun flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  wire logic clk,
  input  wire logic reset,
  uart_rx_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  logic             rx_s;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_ready_q, rx_ready_d;
  logic             frame_error_q, frame_error_d;
  logic             overrun_q, overrun_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync_rx (
    .clk (clk),
    .rst (reset),
    .d   (bus.rx),
    .q   (rx_s)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_ONE;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    frame_error_d = frame_error_q;
    // Acknowledge clears first; a good stop sample below overrides it.
    rx_ready_d    = rx_ready_q & ~bus.clear_ready;
    overrun_d     = overrun_q & ~bus.clear_ready;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end
        end
      end

      DATA: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            rx_data_d     = shift_q;
            rx_ready_d    = 1'b1;
            frame_error_d = 1'b0;
            overrun_d     = overrun_d | (rx_ready_q & ~bus.clear_ready);
            state_d       = IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = BREAK;
          end
        end
      end

      BREAK: begin
        // Hold here until the line returns high so a stuck-low line cannot re-trigger.
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      rx_data_q     <= 8'h00;
      rx_ready_q    <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_ready_q    <= rx_ready_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_ready    = rx_ready_q;
  assign bus.frame_error = frame_error_q;
  assign bus.overrun     = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx at 16 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] data, input logic rdy,
                            input logic fe, input logic ovr);
    check({tag, ".data"},    32'(bus.rx_data),     32'(data));
    check({tag, ".ready"},   32'(bus.rx_ready),    32'(rdy));
    check({tag, ".ferr"},    32'(bus.frame_error), 32'(fe));
    check({tag, ".overrun"}, 32'(bus.overrun),     32'(ovr));
  endtask

  // Start bit driven 1 time unit after an edge; returns one full bit after the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1 bus.rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(CPB);
      bus.rx = b[i];
    end
    tick(CPB);
    bus.rx = stop;
    tick(CPB);
  endtask

  task automatic pulse_clear();
    bus.clear_ready = 1'b1;
    tick(1);
    bus.clear_ready = 1'b0;
  endtask

  initial begin
    bus.rx          = 1'b1;
    bus.clear_ready = 1'b0;

    // Reset values
    tick(3);
    reset = 1'b0;
    check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset.state", 32'(dut.state_q), 32'(ST_IDLE));

    // Single byte with exact latency: ready rises 155 edges after the start edge
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1 check("lat.ready_early", 32'(bus.rx_ready), 32'd0);
        tick(1);
        check_outs("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
      end
    join

    // Acknowledge race
    pulse_clear();
    check("ack0.ready", 32'(bus.rx_ready), 32'd0);
    send_frame(8'h3C, 1'b1);
    check_outs("3c", 8'h3C, 1'b1, 1'b0, 1'b0);
    pulse_clear();
    check_outs("3c_ack", 8'h3C, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'h7E, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1 bus.clear_ready = 1'b1;
        tick(1);
        bus.clear_ready = 1'b0;
        check_outs("7e_race", 8'h7E, 1'b1, 1'b0, 1'b0);
      end
    join

    // Overrun
    pulse_clear();
    send_frame(8'h11, 1'b1);
    check_outs("11", 8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1);
    check_outs("22_ovr", 8'h22, 1'b1, 1'b0, 1'b1);
    pulse_clear();
    check_outs("22_ack", 8'h22, 1'b0, 1'b0, 1'b0);

    // Framing error then held break
    send_frame(8'h55, 1'b0);
    check_outs("55_ferr", 8'h22, 1'b0, 1'b1, 1'b0);
    tick(40 * CPB);
    check_outs("break", 8'h22, 1'b0, 1'b1, 1'b0);
    check("break.state", 32'(dut.state_q), 32'(ST_BREAK));
    bus.rx = 1'b1;
    tick(2 * CPB);
    send_frame(8'h0F, 1'b1);
    check_outs("0f", 8'h0F, 1'b1, 1'b0, 1'b0);

    // Glitch rejection: 4-cycle low pulse
    @(posedge clk);
    #1 bus.rx = 1'b0;
    tick(4);
    bus.rx = 1'b1;
    check("glitch.in_start", 32'(dut.state_q), 32'(ST_START));
    tick(3 * CPB);
    check("glitch.state", 32'(dut.state_q), 32'(ST_IDLE));
    check_outs("glitch", 8'h0F, 1'b1, 1'b0, 1'b0);

    // Reset during data bit 3, then a clean frame
    @(posedge clk);
    #1 bus.rx = 1'b0;
    tick(CPB);
    bus.rx = 1'b1;
    tick(3 * CPB + 8);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check_outs("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
    check("midrst.state", 32'(dut.state_q), 32'(ST_IDLE));
    tick(CPB);
    send_frame(8'h5A, 1'b1);
    check_outs("5a", 8'h5A, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
